// File: rtl/sr_flag_arbiter_if.sv
// Request/ack bundle between flag writers and the flag arbiter.
// Per-requester fields are packed side by side, requester 0 in the LSBs.
interface sr_flag_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDXW = 3
);
    logic [NREQ-1:0]      req_valid;
    logic [2*NREQ-1:0]    req_op;
    logic [IDXW*NREQ-1:0] req_idx;
    logic [NREQ-1:0]      req_ready;

    modport master (
        output req_valid,
        output req_op,
        output req_idx,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_idx,
        output req_ready
    );
endinterface

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbitrated bank of set/reset flags with exact complement output.
// Define SR_FLAG_TOGGLE_EN to make op 11 toggle the flag instead of flagging an error.
module sr_flag_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int NFLAG = 6,
    localparam int IDXW  = (NFLAG > 1) ? $clog2(NFLAG) : 1,
    localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr_all,
    sr_flag_arbiter_if.slave bus,
    output logic [NFLAG-1:0] o_flags,
    output logic [NFLAG-1:0] o_flags_b,
    output logic [GW-1:0]    o_grant_id,
    output logic             o_err_illegal,
    output logic             o_err_range
);

    logic [NFLAG-1:0] r_flags;
    logic [GW-1:0]    r_ptr;
    logic [GW-1:0]    r_gid;
    logic             r_err_range;

    logic             w_any;
    logic             w_go;
    logic [GW-1:0]    w_win;
    logic [GW-1:0]    w_next;
    logic [1:0]       w_op;
    logic [IDXW-1:0]  w_idx;
    logic             w_inrange;
    logic [NFLAG-1:0] w_mask;
    logic [NFLAG-1:0] w_flags_nx;

    // Scan downward so the requester closest to r_ptr is the last writer.
    always_comb begin
        int k;
        w_any = 1'b0;
        w_win = '0;
        k     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = int'(r_ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            if (bus.req_valid[k]) begin
                w_any = 1'b1;
                w_win = GW'(k);
            end
        end
    end

    assign w_go          = w_any & ~rst & ~i_clr_all;
    assign bus.req_ready = w_go ? (NREQ'(1) << w_win) : '0;

    assign w_op      = bus.req_op[2*int'(w_win) +: 2];
    assign w_idx     = bus.req_idx[IDXW*int'(w_win) +: IDXW];
    assign w_inrange = int'(w_idx) < NFLAG;
    assign w_mask    = w_inrange ? (NFLAG'(1) << w_idx) : '0;
    assign w_next    = (w_win == GW'(NREQ - 1)) ? '0 : w_win + 1'b1;

    always_comb begin
        w_flags_nx = r_flags;
        case (w_op)
            2'b01:   w_flags_nx = r_flags & ~w_mask;
            2'b10:   w_flags_nx = r_flags | w_mask;
`ifdef SR_FLAG_TOGGLE_EN
            2'b11:   w_flags_nx = r_flags ^ w_mask;
`endif
            default: w_flags_nx = r_flags;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags     <= '0;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_err_range <= 1'b0;
        end else if (i_clr_all) begin
            r_flags <= '0;
        end else if (w_go) begin
            r_flags <= w_flags_nx;
            r_ptr   <= w_next;
            r_gid   <= w_win;
            if (!w_inrange) r_err_range <= 1'b1;
        end
    end

`ifdef SR_FLAG_TOGGLE_EN
    assign o_err_illegal = 1'b0;
`else
    logic r_err_illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_illegal <= 1'b0;
        end else if (w_go && w_op == 2'b11) begin
            r_err_illegal <= 1'b1;
        end
    end

    assign o_err_illegal = r_err_illegal;
`endif

    assign o_flags     = r_flags;
    assign o_flags_b   = ~r_flags;
    assign o_grant_id  = r_gid;
    assign o_err_range = r_err_range;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Randomized bench for sr_flag_arbiter against a behavioural flag-bank model.
// Honours SR_FLAG_TOGGLE_EN the same way the design does.
module tb_sr_flag_arbiter;

    localparam int NREQ  = 4;
    localparam int NFLAG = 6;
    localparam int IDXW  = 3;
    localparam int GW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr_all;
    logic [NFLAG-1:0] flags;
    logic [NFLAG-1:0] flags_b;
    logic [GW-1:0]    grant_id;
    logic             err_illegal;
    logic             err_range;

    int total = 0;
    int bad   = 0;

    // reference state
    int m_flags [NFLAG];
    int m_ptr;
    int m_gid;
    int m_eill;
    int m_erng;

    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW)) bus ();

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_clr_all     (clr_all),
        .bus           (bus),
        .o_flags       (flags),
        .o_flags_b     (flags_b),
        .o_grant_id    (grant_id),
        .o_err_illegal (err_illegal),
        .o_err_range   (err_range)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_flags();
        logic [31:0] v = '0;
        for (int i = 0; i < NFLAG; i++) v[i] = (m_flags[i] != 0);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NFLAG; i++) m_flags[i] = 0;
        m_ptr  = 0;
        m_gid  = 0;
        m_eill = 0;
        m_erng = 0;
    endtask

    // one clock: check state, drive inputs, check ready, advance model
    task automatic cycle(input logic r, input logic c, input logic [3:0] v,
                         input logic [7:0] op, input logic [11:0] idx);
        int win;
        int o;
        int t;
        logic [31:0] fexp;
        @(negedge clk);
        fexp = model_flags();
        chk("flags", {26'd0, flags}, fexp);
        chk("flags_b", {26'd0, flags_b}, {26'd0, ~fexp[5:0]});
        chk("grant_id", {30'd0, grant_id}, m_gid);
        chk("err_illegal", {31'd0, err_illegal}, m_eill);
        chk("err_range", {31'd0, err_range}, m_erng);
        rst           = r;
        clr_all       = c;
        bus.req_valid = v;
        bus.req_op    = op;
        bus.req_idx   = idx;
        #1;
        win = -1;
        if (!r && !c) begin
            for (int off = NREQ - 1; off >= 0; off--) begin
                if (v[(m_ptr + off) % NREQ]) win = (m_ptr + off) % NREQ;
            end
        end
        chk("ready", {28'd0, bus.req_ready},
            (win < 0) ? 32'd0 : (32'd1 << win));
        @(posedge clk);
        if (r) begin
            model_reset();
        end else if (c) begin
            for (int i = 0; i < NFLAG; i++) m_flags[i] = 0;
        end else if (win >= 0) begin
            m_ptr = (win + 1) % NREQ;
            m_gid = win;
            o = int'(op[2*win +: 2]);
            t = int'(idx[3*win +: 3]);
`ifndef SR_FLAG_TOGGLE_EN
            if (o == 3) m_eill = 1;
`endif
            if (t >= NFLAG) m_erng = 1;
            else if (o == 1) m_flags[t] = 0;
            else if (o == 2) m_flags[t] = 1;
`ifdef SR_FLAG_TOGGLE_EN
            else if (o == 3) m_flags[t] = 1 - m_flags[t];
`endif
        end
    endtask

    initial begin
        rst           = 1'b1;
        clr_all       = 1'b0;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_idx   = '0;
        model_reset();

        cycle(1, 0, 4'b0000, 8'h00, 12'h000);
        cycle(1, 0, 4'b1111, 8'hAA, 12'h000);
        #1 chk("rst_flags_b", {26'd0, flags_b}, 32'h3F);

        // req0 set flag 2, then clear it
        cycle(0, 0, 4'b0001, 8'b10, 12'd2);
        #1 chk("set2", {26'd0, flags}, 32'b000100);
        cycle(0, 0, 4'b0001, 8'b01, 12'd2);
        #1 chk("clr2", {26'd0, flags}, 32'd0);

        // all valid, nops: rotation from ptr=1 continues 1,2,3,0,1
        for (int i = 0; i < 5; i++) cycle(0, 0, 4'b1111, 8'h00, 12'h000);

        // fill all flags via req0
        for (int i = 0; i < NFLAG; i++)
            cycle(0, 0, 4'b0001, 8'b10, 12'(i));
        #1 chk("all_set", {26'd0, flags}, 32'h3F);

        // clr_all blocks the pending req1 set, which lands afterwards
        cycle(0, 1, 4'b0010, 8'b1000, 12'h000);
        #1 chk("clr_all", {26'd0, flags}, 32'd0);
        cycle(0, 0, 4'b0010, 8'b1000, 12'h000);
        #1 chk("after_clr", {26'd0, flags}, 32'b000001);

        // out-of-range index from req2
        cycle(0, 0, 4'b0100, 8'b10_0000, 12'd7 << 6);
        #1 chk("range_err", {31'd0, err_range}, 32'd1);
        cycle(0, 0, 4'b0000, 8'h00, 12'h000);

        // op 11 on flag 1 from req3 with flags=000010
        cycle(0, 0, 4'b0001, 8'b01, 12'd0);
        cycle(0, 0, 4'b0010, 8'b1000, 12'd1 << 3);
        #1 chk("pre11", {26'd0, flags}, 32'b000010);
        cycle(0, 0, 4'b1000, 8'b11 << 6, 12'd1 << 9);
`ifdef SR_FLAG_TOGGLE_EN
        #1 chk("op11", {26'd0, flags}, 32'd0);
        chk("op11_err", {31'd0, err_illegal}, 32'd0);
`else
        #1 chk("op11", {26'd0, flags}, 32'b000010);
        chk("op11_err", {31'd0, err_illegal}, 32'd1);
`endif

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 11) == 0),
                  4'($urandom), 8'($urandom), 12'($urandom));
        end
        cycle(0, 0, 4'b0000, 8'h00, 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
